// File: rtl/regslice_pipe_en_sync_rstn_vector.sv
// Elastic valid/ready pipeline register, STAGES deep, with a run-time reset vector and occupancy count.
// Optional synchronous flush port when SVLIB_REGSLICE_FLUSH_EN is defined.
`timescale 1ns/1ps
module regslice_pipe_en_sync_rstn_vector #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [WIDTH-1:0]              reset_vector,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
`ifdef SVLIB_REGSLICE_FLUSH_EN
    ,
    input  logic                          flush
`endif
);
    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [WIDTH-1:0]  dat_d [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [STAGES-1:0] rdy;
    logic              flush_act;
    logic              in_fire;
    logic              out_fire;

`ifdef SVLIB_REGSLICE_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // A stage is ready if it, or any stage downstream of it, has a hole, or the consumer takes a beat.
    function automatic logic [STAGES-1:0] ready_chain(input logic [STAGES-1:0] v, input logic ordy);
        logic [STAGES-1:0] r;
        logic              acc;
        acc = ordy;
        r   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc  = acc | ~v[k];
            r[k] = acc;
        end
        return r;
    endfunction

    always_comb begin
        rdy       = ready_chain(vld_q, out_ready);
        in_ready  = rdy[0] & ~flush_act;
        out_valid = vld_q[STAGES-1];
        out_data  = dat_q[STAGES-1];
        occupancy = occ_q;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;

        vld_d = vld_q;
        dat_d = dat_q;
        occ_d = occ_q;

        if (in_fire) begin
            vld_d[0] = 1'b1;
            dat_d[0] = in_data;
        end else if (rdy[0]) begin
            vld_d[0] = 1'b0;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (vld_q[k-1] && rdy[k]) begin
                vld_d[k] = 1'b1;
                dat_d[k] = dat_q[k-1];
            end else if (rdy[k]) begin
                vld_d[k] = 1'b0;
            end
        end

        case ({in_fire, out_fire})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Flush discards everything; an output fire this cycle has already been consumed downstream.
        if (flush_act) begin
            vld_d = '0;
            occ_d = '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_d[k] = reset_vector;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= reset_vector;
            end
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_regslice_pipe_en_sync_rstn_vector.sv
// Directed vector table plus scoreboard-checked sequences for the elastic pipeline register (STAGES=3).
`timescale 1ns/1ps
module tb_regslice_pipe_en_sync_rstn_vector;
    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] reset_vector;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef SVLIB_REGSLICE_FLUSH_EN
    logic         flush = 1'b0;
`endif

    regslice_pipe_en_sync_rstn_vector #(.WIDTH(W), .STAGES(S)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .reset_vector (reset_vector),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy)
`ifdef SVLIB_REGSLICE_FLUSH_EN
        ,
        .flush        (flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rstn;
        logic [W-1:0] rv;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         chk;
        logic         ov;
        logic [W-1:0] od;
        logic         ir;
        logic [1:0]   occ;
    } vec_t;

    vec_t         tv [$];
    logic [W-1:0] sb [$];
    int           vec_cnt = 0;
    int           err_cnt = 0;
    int           out_cnt = 0;

    function automatic vec_t mk(logic r, logic [W-1:0] rv, logic iv, logic [W-1:0] id, logic ordy,
                                logic c, logic ov, logic [W-1:0] od, logic ir, logic [1:0] occ);
        vec_t v;
        v.rstn = r; v.rv = rv; v.iv = iv; v.id = id; v.ordy = ordy;
        v.chk = c; v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One handshake cycle against the queue model; checks are taken mid-cycle before the edge.
    task automatic cyc(input logic iv, input logic [W-1:0] id, input logic ordy, output logic fired);
        rstn = 1'b1; in_valid = iv; in_data = id; out_ready = ordy;
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < S) || ordy});
        check("occupancy", {30'd0, occupancy}, sb.size());
        if (occupancy > S) check("occ_bound", {30'd0, occupancy}, S);
        if (out_valid) begin
            if (sb.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else                check("out_data", {24'd0, out_data}, {24'd0, sb[0]});
        end
        fired = iv && in_ready;
        if (out_valid && ordy && sb.size() > 0) begin
            void'(sb.pop_front());
            out_cnt++;
        end
        if (fired) sb.push_back(id);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic [W-1:0] rv);
        rstn = 1'b0; reset_vector = rv; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        out_cnt = 0;
        rstn = 1'b1;
    endtask

    task automatic drain;
        logic f;
        for (int i = 0; i < 2 * S + 2; i++) cyc(1'b0, 8'h00, 1'b1, f);
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        logic       f;
        logic       pv;
        logic [W-1:0] pd;

        rstn = 1'b0; reset_vector = 8'hA5; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        //              rstn rv    iv id     or  chk ov od     ir occ
        tv.push_back(mk(0, 8'hA5, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tv.push_back(mk(0, 8'hA5, 0, 8'h00, 1, 1, 0, 8'hA5, 1, 0));
        tv.push_back(mk(1, 8'hA5, 1, 8'h11, 1, 1, 0, 8'hA5, 1, 0));
        tv.push_back(mk(1, 8'hA5, 0, 8'h00, 1, 1, 0, 8'hA5, 1, 1));
        tv.push_back(mk(1, 8'hA5, 0, 8'h00, 1, 1, 0, 8'hA5, 1, 1));
        tv.push_back(mk(1, 8'hA5, 0, 8'h00, 1, 1, 1, 8'h11, 1, 1));
        tv.push_back(mk(1, 8'hA5, 1, 8'h01, 0, 1, 0, 8'h11, 1, 0));
        tv.push_back(mk(1, 8'hA5, 1, 8'h02, 0, 1, 0, 8'h11, 1, 1));
        tv.push_back(mk(1, 8'hA5, 1, 8'h03, 0, 1, 0, 8'h11, 1, 2));
        tv.push_back(mk(1, 8'hA5, 1, 8'h04, 0, 1, 1, 8'h01, 0, 3));
        tv.push_back(mk(1, 8'hA5, 1, 8'h04, 0, 1, 1, 8'h01, 0, 3));
        tv.push_back(mk(1, 8'hA5, 1, 8'h04, 1, 1, 1, 8'h01, 1, 3));
        tv.push_back(mk(1, 8'hA5, 1, 8'h05, 1, 1, 1, 8'h02, 1, 3));
        tv.push_back(mk(1, 8'hA5, 0, 8'h00, 1, 1, 1, 8'h03, 1, 3));
        tv.push_back(mk(1, 8'hA5, 0, 8'h00, 1, 1, 1, 8'h04, 1, 2));
        tv.push_back(mk(1, 8'hA5, 0, 8'h00, 1, 1, 1, 8'h05, 1, 1));
        tv.push_back(mk(1, 8'hA5, 1, 8'h66, 0, 1, 0, 8'h05, 1, 0));
        tv.push_back(mk(1, 8'hA5, 0, 8'h00, 0, 1, 0, 8'h05, 1, 1));
        tv.push_back(mk(1, 8'hA5, 0, 8'h00, 0, 1, 0, 8'h05, 1, 1));
        tv.push_back(mk(0, 8'h3C, 0, 8'h00, 0, 1, 1, 8'h66, 1, 1));
        tv.push_back(mk(1, 8'h3C, 0, 8'h00, 1, 1, 0, 8'h3C, 1, 0));

        foreach (tv[i]) begin
            rstn = tv[i].rstn; reset_vector = tv[i].rv; in_valid = tv[i].iv;
            in_data = tv[i].id; out_ready = tv[i].ordy;
            @(negedge clk);
            if (tv[i].chk) begin
                check($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].ov});
                check($sformatf("v%0d.out_data", i), {24'd0, out_data}, {24'd0, tv[i].od});
                check($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].ir});
                check($sformatf("v%0d.occupancy", i), {30'd0, occupancy}, {30'd0, tv[i].occ});
            end
            @(posedge clk); #1;
        end

        // Full rate: one beat per cycle, occupancy settles at S.
        do_reset(8'h00);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 8'(i), 1'b1, f);
            if (i >= S) check("fullrate_occ", {30'd0, occupancy}, S);
        end
        drain();
        check("fullrate_count", out_cnt, 32'd100);

        // Random handshakes; producer holds a beat until it is taken.
        do_reset(8'h5A);
        pv = 1'b0; pd = '0;
        for (int c = 0; c < 4000; c++) begin
            if (!pv) begin
                pv = 1'($urandom_range(0, 1));
                pd = 8'($urandom);
            end
            cyc(pv, pd, ($urandom_range(0, 3) != 0), f);
            if (f) pv = 1'b0;
        end
        drain();

`ifdef SVLIB_REGSLICE_FLUSH_EN
        do_reset(8'hC3);
        for (int i = 0; i < S; i++) cyc(1'b1, 8'(8'hE0 + i), 1'b0, f);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        check("flush_pre_occ", {30'd0, occupancy}, S);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_out_data", {24'd0, out_data}, 32'hC3);
        check("flush_occ", {30'd0, occupancy}, 32'd0);
        @(posedge clk); #1;
        sb.delete();
        cyc(1'b1, 8'h42, 1'b0, f);
        rstn = 1'b0; flush = 1'b1; reset_vector = 8'h9E; in_valid = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flush_out_data", {24'd0, out_data}, 32'h9E);
        check("rst_flush_occ", {30'd0, occupancy}, 32'd0);
        check("rst_flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
